// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the hazard controller: forward-select
// encoding, stall FSM states, shadow-stage records and the match helpers.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_e;

  // Destination info carried by every shadow stage.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwen;
    logic             load;
  } stage_t;

  // X additionally remembers its sources so forwarding can be decided there.
  typedef struct packed {
    stage_t           dst;
    logic [REG_W-1:0] rs1;
    logic             use_rs1;
    logic [REG_W-1:0] rs2;
    logic             use_rs2;
  } x_stage_t;

  // A producer stage satisfies a consumer source. x0 never matches.
  // block_load excludes loads, whose data is not ready until W.
  function automatic logic fwd_hit(input stage_t           s,
                                   input logic [REG_W-1:0] rs,
                                   input logic             use_rs,
                                   input logic             block_load);
    return s.regwen && use_rs && (s.rd != '0) && (s.rd == rs) &&
           !(block_load && s.load);
  endfunction

  // M beats W because it holds the younger write to the same register.
  function automatic fwd_sel_e fwd_select(input stage_t           m,
                                          input stage_t           w,
                                          input logic [REG_W-1:0] rs,
                                          input logic             use_rs);
    if (fwd_hit(m, rs, use_rs, 1'b1)) return FWD_MEM;
    if (fwd_hit(w, rs, use_rs, 1'b0)) return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] value
);

  logic [CNT_W-1:0] value_q;

  // Count qualifying cycles, sticking at all-ones instead of wrapping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else if (clear) begin
      value_q <= '0;
    end else if (inc && (value_q != '1)) begin
      value_q <= value_q + 1'b1;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and X-stage
// operand forwarding, driven by a shadow copy of the X/M/W destinations.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [REG_W-1:0] rs1_D,
  input  logic [REG_W-1:0] rs2_D,
  input  logic [REG_W-1:0] rd_D,
  input  logic             use_rs1_D,
  input  logic             use_rs2_D,
  input  logic             regwen_D,
  input  logic             load_D,
  input  logic             pcsel_X,
  output logic             nop,
  output logic             pcsel_f,
  output logic             pc_hold,
  output logic [1:0]       fwdA_X,
  output logic [1:0]       fwdB_X,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Stall cycles still owed after the hazard cycle itself.
  localparam logic [1:0] STALL_LOAD = 2'(LOAD_USE_STALL - 1);

  x_stage_t     x_q, x_d;
  stage_t       m_q, m_d;
  stage_t       w_q, w_d;
  stall_state_e state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         hazard;
  logic         stall;
  fwd_sel_e     fwd_a, fwd_b;

  // Load in X whose result the D instruction needs next cycle.
  assign hazard = x_q.dst.load && (x_q.dst.rd != '0) &&
                  ((use_rs1_D && (rs1_D == x_q.dst.rd)) ||
                   (use_rs2_D && (rs2_D == x_q.dst.rd)));

  // Stall FSM next state; a taken branch cancels any stall in progress.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (pcsel_X) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hazard) begin
            stall = 1'b1;
            if (STALL_LOAD != 2'd0) begin
              state_d = STALL;
              cnt_d   = STALL_LOAD;
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Stall FSM state and remaining-bubble counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // pcsel_X is an external input, so it is masked while reset is held.
  assign pcsel_f = pcsel_X & reset_n;
  assign nop     = stall;
  assign pc_hold = stall;

  // Shadow advance: X takes a bubble whenever the real X register does.
  always_comb begin
    m_d = x_q.dst;
    w_d = m_q;
    x_d = '0;
    if (!(stall || pcsel_f)) begin
      x_d.dst.rd     = rd_D;
      x_d.dst.regwen = regwen_D;
      x_d.dst.load   = load_D;
      x_d.rs1        = rs1_D;
      x_d.use_rs1    = use_rs1_D;
      x_d.rs2        = rs2_D;
      x_d.use_rs2    = use_rs2_D;
    end
  end

  // Shadow X/M/W registers; reset empties the pipeline.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      x_q <= x_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Operand forward selects for the instruction in X.
  always_comb begin
    fwd_a = fwd_select(m_q, w_q, x_q.rs1, x_q.use_rs1);
    fwd_b = fwd_select(m_q, w_q, x_q.rs2, x_q.use_rs2);
  end

  assign fwdA_X = fwd_a;
  assign fwdB_X = fwd_b;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (nop),
    .clear   (1'b0),
    .value   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (pcsel_f),
    .clear   (1'b0),
    .value   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table run on the single-bubble
// instance, then hand sequences on a 3-bubble, 4-bit-counter instance.
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] rs1_D, rs2_D, rd_D;
  logic       use_rs1_D, use_rs2_D, regwen_D, load_D, pcsel_X;

  logic        nop1, pcf1, hold1;
  logic [1:0]  fa1, fb1;
  logic [31:0] sc1, fc1;
  logic        nop3, pcf3, hold3;
  logic [1:0]  fa3, fb3;
  logic [3:0]  sc3, fc3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hazard_ctrl u_dut1 (
    .clock(clock), .reset_n(reset_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
    .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .regwen_D(regwen_D), .load_D(load_D), .pcsel_X(pcsel_X),
    .nop(nop1), .pcsel_f(pcf1), .pc_hold(hold1),
    .fwdA_X(fa1), .fwdB_X(fb1), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_ctrl #(.LOAD_USE_STALL(3), .CNT_W(4)) u_dut3 (
    .clock(clock), .reset_n(reset_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
    .use_rs1_D(use_rs1_D), .use_rs2_D(use_rs2_D),
    .regwen_D(regwen_D), .load_D(load_D), .pcsel_X(pcsel_X),
    .nop(nop3), .pcsel_f(pcf3), .pc_hold(hold3),
    .fwdA_X(fa3), .fwdB_X(fb3), .stall_cnt(sc3), .flush_cnt(fc3)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wen, ld, pc;
    logic       e_nop, e_pcf;
    logic [1:0] e_fa, e_fb;
    int         e_sc, e_fc;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input int rs1, input int rs2, input int rd,
                              input bit u1, input bit u2, input bit wen,
                              input bit ld, input bit pc,
                              input bit e_nop, input bit e_pcf,
                              input int e_fa, input int e_fb,
                              input int e_sc, input int e_fc);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.u1 = u1; v.u2 = u2; v.wen = wen; v.ld = ld; v.pc = pc;
    v.e_nop = e_nop; v.e_pcf = e_pcf;
    v.e_fa = 2'(e_fa); v.e_fb = 2'(e_fb);
    v.e_sc = e_sc; v.e_fc = e_fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int rs1, input int rs2, input int rd,
                       input bit u1, input bit u2, input bit wen,
                       input bit ld, input bit pc);
    rs1_D = 5'(rs1); rs2_D = 5'(rs2); rd_D = 5'(rd);
    use_rs1_D = u1; use_rs2_D = u2; regwen_D = wen; load_D = ld; pcsel_X = pc;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset pulse released just before an edge; ends one cycle later at edge+1.
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    @(posedge clock);
    #4;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // Vector table: D-stage inputs per cycle and expected outputs of u_dut1.
    //              rs1 rs2 rd u1 u2 wen ld pc  nop pcf fa fb sc fc
    vecs[0]  = mk( 2,  0,  5, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0); // lw x5
    vecs[1]  = mk( 5,  1,  6, 1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0); // add x6,x5,x1 : hazard
    vecs[2]  = mk( 5,  1,  6, 1, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0); // held, X bubble
    vecs[3]  = mk( 1,  2,  3, 1, 1, 1, 0, 0,  0, 0, 2, 0, 1, 0); // add x6 in X, lw in W
    vecs[4]  = mk( 6,  0,  3, 1, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0); // add x3 in X
    vecs[5]  = mk( 0,  3,  8, 1, 1, 1, 0, 0,  0, 0, 2, 0, 1, 0); // rs1=x6 from W, rs2=x0
    vecs[6]  = mk( 3,  8,  9, 1, 1, 1, 0, 0,  0, 0, 0, 1, 1, 0); // x3 in M and W: M wins
    vecs[7]  = mk( 1,  0,  0, 1, 0, 1, 1, 0,  0, 0, 2, 1, 1, 0); // x3 from W, x8 from M
    vecs[8]  = mk( 0,  0, 10, 1, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0); // lw x0 in X, reader of x0
    vecs[9]  = mk( 9,  0, 12, 1, 0, 1, 1, 0,  0, 0, 0, 0, 1, 0); // x0 reader in X
    vecs[10] = mk(10, 12,  0, 1, 1, 0, 0, 1,  0, 1, 0, 0, 1, 0); // branch + load-use hazard
    vecs[11] = mk(12,  0, 13, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1, 1); // X flushed to bubble
    vecs[12] = mk( 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 1, 1); // x12 consumer gets W
    vecs[13] = mk( 0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);

    // Reset state, with a taken branch presented during reset.
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    check("rst_pcsel_f", 32'(pcf1), 0);
    check("rst_nop", 32'(nop1), 0);
    check("rst_pc_hold", 32'(hold1), 0);
    check("rst_fwdA", 32'(fa1), 0);
    check("rst_fwdB", 32'(fb1), 0);
    check("rst_stall_cnt", sc1, 0);
    check("rst_flush_cnt", fc1, 0);
    check("rst_nop_s3", 32'(nop3), 0);
    do_reset();

    // Table pass on u_dut1.
    for (int i = 0; i < 14; i++) begin
      drive(int'(vecs[i].rs1), int'(vecs[i].rs2), int'(vecs[i].rd),
            vecs[i].u1, vecs[i].u2, vecs[i].wen, vecs[i].ld, vecs[i].pc);
      #2;
      check($sformatf("v%0d_nop", i), 32'(nop1), 32'(vecs[i].e_nop));
      check($sformatf("v%0d_pc_hold", i), 32'(hold1), 32'(vecs[i].e_nop));
      check($sformatf("v%0d_pcsel_f", i), 32'(pcf1), 32'(vecs[i].e_pcf));
      check($sformatf("v%0d_fwdA", i), 32'(fa1), 32'(vecs[i].e_fa));
      check($sformatf("v%0d_fwdB", i), 32'(fb1), 32'(vecs[i].e_fb));
      check($sformatf("v%0d_stall_cnt", i), sc1, 32'(vecs[i].e_sc));
      check($sformatf("v%0d_flush_cnt", i), fc1, 32'(vecs[i].e_fc));
      tick();
    end

    // Three-bubble stall on u_dut3: nop for exactly 3 cycles.
    do_reset();
    drive(2, 0, 5, 1, 0, 1, 1, 0);
    #2;
    check("s3_pre_nop", 32'(nop3), 0);
    tick();
    drive(5, 1, 6, 1, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #2;
      check($sformatf("s3_nop_c%0d", k), 32'(nop3), 1);
      check($sformatf("s3_hold_c%0d", k), 32'(hold3), 1);
      tick();
    end
    #2;
    check("s3_nop_end", 32'(nop3), 0);
    check("s3_stall_cnt", 32'(sc3), 3);
    tick();

    // Branch arriving in the middle of a stall discards the rest of it.
    do_reset();
    drive(2, 0, 5, 1, 0, 1, 1, 0);
    tick();
    drive(5, 1, 6, 1, 1, 1, 0, 0);
    #2;
    check("fl_hazard_nop", 32'(nop3), 1);
    tick();
    pcsel_X = 1'b1;
    #2;
    check("fl_stall_nop", 32'(nop3), 0);
    check("fl_stall_pcsel_f", 32'(pcf3), 1);
    tick();
    pcsel_X = 1'b0;
    #2;
    check("fl_after_nop", 32'(nop3), 0);
    check("fl_after_flush_cnt", 32'(fc3), 1);
    tick();

    // Reset asserted in cycle 2 of a 3-cycle stall.
    do_reset();
    drive(2, 0, 5, 1, 0, 1, 1, 0);
    tick();
    drive(5, 1, 6, 1, 1, 1, 0, 0);
    #2;
    check("rs_c1_nop", 32'(nop3), 1);
    tick();
    #2;
    check("rs_c2_nop", 32'(nop3), 1);
    reset_n = 1'b0;
    #1;
    check("rs_abort_nop", 32'(nop3), 0);
    check("rs_abort_hold", 32'(hold3), 0);
    check("rs_abort_stall_cnt", 32'(sc3), 0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2;
      check($sformatf("rs_post_nop_c%0d", k), 32'(nop3), 0);
      tick();
    end

    // Counter saturation: 20 flush cycles against a 4-bit counter.
    do_reset();
    check("sat_start", 32'(fc3), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 14) check("sat_reach15", 32'(fc3), 15);
    end
    pcsel_X = 1'b0;
    #2;
    check("sat_hold15", 32'(fc3), 15);
    check("wide_flush_cnt", fc1, 20);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning): the block SHALL have these two parameters.
  - LOAD_USE_STALL, 1, bubble cycles inserted per load-use hazard (1..3).
  - CNT_W, 32, width of the performance counters.
REQ-002 Ports (name, direction, width, meaning): the block SHALL have these ports, listed in this order.
  - clock, in, 1, single clock.
  - reset_n, in, 1, asynchronous active-low reset.
  - rs1_D, in, 5, source register 1 of the D-stage instruction.
  - rs2_D, in, 5, source register 2 of the D-stage instruction.
  - rd_D, in, 5, destination register of the D-stage instruction.
  - use_rs1_D, in, 1, the D-stage instruction reads rs1.
  - use_rs2_D, in, 1, the D-stage instruction reads rs2.
  - regwen_D, in, 1, the D-stage instruction writes rd.
  - load_D, in, 1, the D-stage instruction is a load (WBSel = DataR).
  - pcsel_X, in, 1, branch or jump taken in X.
  - nop, out, 1, stall pulse to the pipeline registers.
  - pcsel_f, out, 1, flush pulse to the pipeline registers.
  - pc_hold, out, 1, hold the fetch PC.
  - fwdA_X, out, 2, operand A forward select in X (0 = rs1Xo, 1 = aluMo, 2 = W writeback data).
  - fwdB_X, out, 2, operand B forward select in X (same encoding as fwdA_X).
  - stall_cnt, out, CNT_W, number of stall cycles.
  - flush_cnt, out, CNT_W, number of flush cycles.

Function
REQ-003 Shadow pipeline: the block SHALL keep a shadow of the X, M and W stages.
  - Each stage holds {rd, regwen, load}; X additionally holds {rs1, use_rs1, rs2, use_rs2}.
  - Every cycle the shadow SHALL advance D->X->M->W, mirroring the pipeline registers.
REQ-004 Bubble injection: on a cycle with nop or pcsel_f asserted, shadow X SHALL be loaded with a bubble (all fields 0), while M and W still advance.
REQ-005 Load-use hazard: a hazard SHALL be detected when all of the following hold.
  - Shadow X has load=1 and rd_X != 0.
  - Either (use_rs1_D and rs1_D == rd_X) or (use_rs2_D and rs2_D == rd_X).
REQ-006 Stall FSM: the stall control SHALL be an FSM with states IDLE and STALL and a down-counter.
  - IDLE->STALL on a hazard with pcsel_X=0; the counter loads LOAD_USE_STALL-1.
  - STALL decrements the counter each cycle and returns to IDLE at count 0.
REQ-007 Stall outputs: nop and pc_hold SHALL be combinational, asserted in the hazard cycle and in every STALL cycle.
  - Total stall length SHALL be exactly LOAD_USE_STALL cycles.
  - The D inputs SHALL be held stable by the pipeline during a stall.
REQ-008 Flush: pcsel_f SHALL equal pcsel_X, combinationally, for exactly the cycle in which pcsel_X is high.
REQ-009 Flush priority: when pcsel_X=1, nop and pc_hold SHALL be 0 and the FSM SHALL go to IDLE.
  - This applies in either state.
  - Any pending stall SHALL be discarded.
REQ-010 Forwarding for fwdA_X (source rs1_X): the select SHALL be chosen in this priority order.
  - 1 if regwen_M=1, rd_M != 0, rd_M == rs1_X and use_rs1_X=1.
  - Otherwise 2 if the same test passes with the W-stage fields.
  - Otherwise 0.
REQ-011 Forwarding for fwdB_X: the select SHALL follow the same rule as REQ-010 using rs2_X and use_rs2_X.
REQ-012 Load in M: fwd = 1 SHALL never be produced for a source whose M entry has load=1.
  - The REQ-007 stall guarantees that such a source resolves to 2 on the following cycle.
REQ-013 Register x0: rd = 0 SHALL never match for forwarding or for the hazard test.
REQ-014 Performance counters: stall_cnt SHALL increment on each cycle with nop=1, and flush_cnt on each cycle with pcsel_f=1.
  - Both counters SHALL saturate at all-ones and not wrap.
REQ-015 Cross-stage behaviour: stall_cnt and flush_cnt SHALL change one cycle after the qualifying event.
  - fwd, nop and pcsel_f SHALL be combinational from the current shadow state and inputs.
  - All other outputs SHALL be registered.

Reset
REQ-016 Reset values: reset_n=0 SHALL asynchronously clear the following.
  - All shadow stages (to bubbles).
  - FSM to IDLE and the counter to 0.
  - stall_cnt and flush_cnt to 0.
REQ-017 Reset outputs: during reset, nop, pcsel_f, pc_hold, fwdA_X and fwdB_X SHALL be 0.
REQ-018 Reset mid-stall: a reset asserted during STALL SHALL abort the stall with no residual bubble after release.
REQ-019 Reset release: reset release SHALL be usable on any clock edge; the first post-reset cycle behaves as IDLE with an empty pipeline.

Structure
REQ-020 Shared package: the shared package SHALL hold the following.
  - The fwd select encoding (FWD_NONE=0, FWD_MEM=1, FWD_WB=2).
  - The FSM state enum.
  - The register-index width constant (5).
REQ-021 Sub-module: the single sub-module SHALL be sat_counter, parameterised by CNT_W with inputs inc and clear and output value; it is instantiated twice.

Verification
REQ-022 Load-use: the bench SHALL cover each of the following.
  - Stimulus: lw x5 in X, D has add x6,x5,x1 (use_rs1_D=1, rs1_D=5).
  - Response: nop=1 and pc_hold=1 for 1 cycle, stall_cnt 0->1.
  - Next cycle: fwdA_X=2.
REQ-023 ALU forwarding:
  - Stimulus: add x3 in M, a consumer in X with rs2_X=3.
  - Response: fwdB_X=1; with x3 also in W, the result is still 1 (M wins).
REQ-024 Branch with simultaneous hazard:
  - Stimulus: pcsel_X=1 in the same cycle as a load-use hazard.
  - Response: pcsel_f=1, nop=0, flush_cnt +1, X becomes a bubble next cycle.
REQ-025 x0 and longer stall: the bench SHALL cover both of the following.
  - Load to x0 followed by a reader of x0: no stall, fwd=0.
  - LOAD_USE_STALL=3: nop held for exactly 3 cycles.
REQ-026 Reset and saturation: the bench SHALL cover both of the following.
  - Deassert reset_n in cycle 2 of a 3-cycle stall: nop=0 immediately, and no nop after release.
  - Preload a counter to all-ones (CNT_W=4, value 15): the counter stays at 15.
